scan_index_gen: RTL and testbench

- Generates the 3-bit index that drives the 3-to-8 one-hot decoder stage (LED or digit select).
- Two modes:
  - Auto-scan: the index advances at a prescaled rate.
  - Manual step: the index advances once per debounced pushbutton press.
- Direction (up/down) and the wrap point are configurable.
- Sits directly upstream of the decoder; `sel` connects straight to the decoder input.

---
 rtl/scan_index_gen.sv | 130 +++++++++++++
 tb/tb_scan_index_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_index_gen.sv
// Purpose: 3-bit scan index for the one-hot decoder, auto-scanned or manually stepped.
// Latency: auto advance every DIV cycles; button press reaches sel DB_CYCLES+3 edges after a clean rise.
// Backpressure: none; sel/tick/wrap are free-running registered outputs.
module scan_index_gen #(
    parameter int DIV       = 100000,
    parameter int DB_CYCLES = 20000,
    parameter int LAST      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step_btn,
    output logic [2:0] sel,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);
    localparam logic [2:0]    SEL_MAX = 3'(LAST);

    typedef enum logic {PAUSE, RUN} state_t;

    logic          run_s1, run_s;
    logic          dir_s1, dir_s;
    logic          btn_s1, btn_s;
    logic [DW-1:0] db_cnt;
    logic          db_lvl, db_lvl_d;
    logic          step_p;
    logic [PW-1:0] pre;
    state_t        state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_s1 <= 1'b0;
            run_s  <= 1'b0;
            dir_s1 <= 1'b0;
            dir_s  <= 1'b0;
            btn_s1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            run_s1 <= run;
            run_s  <= run_s1;
            dir_s1 <= dir;
            dir_s  <= dir_s1;
            btn_s1 <= step_btn;
            btn_s  <= btn_s1;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_lvl   <= 1'b0;
            db_lvl_d <= 1'b0;
        end else begin
            db_lvl_d <= db_lvl;
            if (btn_s != db_lvl) begin
                if (db_cnt == DB_MAX) begin
                    db_lvl <= btn_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign step_p = db_lvl & ~db_lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PAUSE;
            pre   <= '0;
            sel   <= 3'd0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            case (state)
                PAUSE: begin
                    pre <= '0;
                    if (run_s) begin
                        state <= RUN;
                    end else if (step_p) begin
                        tick <= 1'b1;
                        if (!dir_s) begin
                            sel  <= (sel == SEL_MAX) ? 3'd0 : sel + 3'd1;
                            wrap <= (sel == SEL_MAX);
                        end else begin
                            sel  <= (sel == 3'd0) ? SEL_MAX : sel - 3'd1;
                            wrap <= (sel == 3'd0);
                        end
                    end
                end
                RUN: begin
                    // Leaving RUN wins over a terminal prescaler count.
                    if (!run_s) begin
                        state <= PAUSE;
                        pre   <= '0;
                    end else if (pre == PRE_MAX) begin
                        pre  <= '0;
                        tick <= 1'b1;
                        if (!dir_s) begin
                            sel  <= (sel == SEL_MAX) ? 3'd0 : sel + 3'd1;
                            wrap <= (sel == SEL_MAX);
                        end else begin
                            sel  <= (sel == 3'd0) ? SEL_MAX : sel - 3'd1;
                            wrap <= (sel == 3'd0);
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                default: begin
                    state <= PAUSE;
                    pre   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed bench for scan_index_gen: DIV=5, DB_CYCLES=4, with LAST=7 and LAST=3 instances.
module tb_scan_index_gen;

    logic       clk;
    logic       rst_n;
    logic       run, dir, step_btn;
    logic [2:0] sel;
    logic       tick, wrap;
    logic       run3, dir3, btn3;
    logic [2:0] sel3;
    logic       tick3, wrap3;

    int checks   = 0;
    int failures = 0;

    scan_index_gen #(.DIV(5), .DB_CYCLES(4), .LAST(7)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .step_btn(step_btn),
        .sel(sel), .tick(tick), .wrap(wrap)
    );

    scan_index_gen #(.DIV(5), .DB_CYCLES(4), .LAST(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .run(run3), .dir(dir3), .step_btn(btn3),
        .sel(sel3), .tick(tick3), .wrap(wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 0; dir = 0; step_btn = 0;
        run3 = 0; dir3 = 0; btn3 = 0;
        #2;
        checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        checks++; if (sel !== 3'd0 || tick !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset sel=%0d tick=%b exp sel=0 tick=0", sel, tick);
        end
    endtask

    task automatic test_auto_up();
        int last_t;
        int nticks;
        logic [2:0] exp_sel;
        last_t = 0; nticks = 0; exp_sel = 3'd0;
        run = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            cyc();
            if (tick) begin
                exp_sel = (exp_sel == 3'd7) ? 3'd0 : exp_sel + 3'd1;
                nticks++;
                checks++; if (sel !== exp_sel) begin failures++; $display("FAIL up_sel got=%0d exp=%0d", sel, exp_sel); end
                checks++; if (wrap !== (exp_sel == 3'd0)) begin failures++; $display("FAIL up_wrap got=%b exp=%b", wrap, exp_sel == 3'd0); end
                checks++; if (i - last_t !== ((nticks == 1) ? 8 : 5)) begin
                    failures++; $display("FAIL up_period got=%0d exp=%0d", i - last_t, (nticks == 1) ? 8 : 5);
                end
                last_t = i;
            end else if (wrap) begin
                checks++; failures++; $display("FAIL up_wrap_without_tick got=1 exp=0");
            end
        end
        checks++; if (nticks != 8) begin failures++; $display("FAIL up_tick_count got=%0d exp=8", nticks); end
    endtask

    task automatic test_auto_down();
        logic [2:0] exp_sel [3];
        logic       exp_wrap [3];
        bit found;
        exp_sel = '{3'd7, 3'd6, 3'd5};
        exp_wrap = '{1'b1, 1'b0, 1'b0};
        dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            found = 0;
            for (int c = 0; c < 20 && !found; c++) begin
                cyc();
                if (tick) found = 1;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL down_timeout step=%0d got=no_tick exp=tick", k);
            end else if (sel !== exp_sel[k] || wrap !== exp_wrap[k]) begin
                failures++;
                $display("FAIL down_step%0d sel=%0d wrap=%b exp sel=%0d wrap=%b", k, sel, wrap, exp_sel[k], exp_wrap[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        checks++; if (sel !== 3'd5) begin failures++; $display("FAIL pre_reset_sel got=%0d exp=5", sel); end
        #2;
        rst_n = 1'b0;
        run = 1'b0; dir = 1'b0;
        #1;
        checks++; if (sel !== 3'd0) begin failures++; $display("FAIL async_reset_sel got=%0d exp=0", sel); end
        checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin
            failures++; $display("FAIL async_reset_pulses tick=%b wrap=%b exp 0 0", tick, wrap);
        end
        cyc();
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_manual_step();
        int first_t;
        int nticks;
        first_t = -1; nticks = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            cyc();
            if (i == 10) step_btn = 1'b0;
            if (tick) begin
                nticks++;
                if (first_t < 0) begin
                    first_t = i;
                    checks++; if (sel !== 3'd1) begin failures++; $display("FAIL manual_sel got=%0d exp=1", sel); end
                end
            end
        end
        checks++; if (first_t != 7) begin failures++; $display("FAIL manual_latency got=%0d exp=7", first_t); end
        checks++; if (nticks != 1) begin failures++; $display("FAIL manual_tick_count got=%0d exp=1", nticks); end
    endtask

    task automatic test_bounce();
        logic bounce [5];
        logic glitch [10];
        int nticks;
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        glitch = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        nticks = 0;
        for (int i = 0; i < 5; i++) begin
            step_btn = bounce[i];
            cyc();
            if (tick) nticks++;
        end
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin cyc(); if (tick) nticks++; end
        step_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin cyc(); if (tick) nticks++; end
        checks++; if (nticks != 1) begin failures++; $display("FAIL bounce_tick_count got=%0d exp=1", nticks); end
        checks++; if (sel !== 3'd2) begin failures++; $display("FAIL bounce_sel got=%0d exp=2", sel); end
        nticks = 0;
        for (int i = 0; i < 10; i++) begin
            step_btn = glitch[i];
            cyc();
            if (tick) nticks++;
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin cyc(); if (tick) nticks++; end
        checks++; if (nticks != 0) begin failures++; $display("FAIL glitch_tick_count got=%0d exp=0", nticks); end
        checks++; if (sel !== 3'd2) begin failures++; $display("FAIL glitch_sel got=%0d exp=2", sel); end
    endtask

    task automatic test_last3_and_run_drop();
        logic [2:0] exp_sel;
        logic [2:0] held;
        int nticks;
        int bad;
        bit found;
        exp_sel = 3'd0; nticks = 0; bad = 0;
        run3 = 1'b1; dir3 = 1'b0;
        for (int i = 0; i < 45; i++) begin
            cyc();
            if (sel3 > 3'd3) bad++;
            if (tick3) begin
                exp_sel = (exp_sel == 3'd3) ? 3'd0 : exp_sel + 3'd1;
                nticks++;
                checks++; if (sel3 !== exp_sel || wrap3 !== (exp_sel == 3'd0)) begin
                    failures++;
                    $display("FAIL last3_step sel=%0d wrap=%b exp sel=%0d wrap=%b", sel3, wrap3, exp_sel, exp_sel == 3'd0);
                end
            end
        end
        checks++; if (nticks != 8) begin failures++; $display("FAIL last3_tick_count got=%0d exp=8", nticks); end
        checks++; if (bad != 0) begin failures++; $display("FAIL last3_range got=%0d_cycles_above_3 exp=0", bad); end
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            if (tick3) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL last3_sync_timeout got=no_tick exp=tick"); end
        held = sel3;
        // run_s falls exactly on the cycle the prescaler sits at DIV-1.
        cyc(); cyc();
        run3 = 1'b0;
        nticks = 0;
        for (int i = 0; i < 12; i++) begin cyc(); if (tick3) nticks++; end
        checks++; if (nticks != 0) begin failures++; $display("FAIL run_drop_tick got=%0d exp=0", nticks); end
        checks++; if (sel3 !== held) begin failures++; $display("FAIL run_drop_sel got=%0d exp=%0d", sel3, held); end
    endtask

    initial begin
        test_reset();
        test_auto_up();
        test_auto_down();
        test_async_reset();
        test_manual_step();
        test_bounce();
        test_last3_and_run_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
